// File: rtl/inv_oai_slice_pipe.sv
// Registered INV/OAI222 slice datapath behind a valid/ready handshake.
// Results are queued in a small output FIFO. A sticky reserved-mode flag and a transfer counter are also kept.
module inv_oai_slice_pipe #(
    parameter int LANES = 9,
    parameter int DEPTH = 2,
    parameter int CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [4*LANES-1:0]   in_a,
    input  logic [4*LANES-1:0]   in_b,
    input  logic [1:0]           in_mode,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [4*LANES-1:0]   out_c,
    output logic                 err,
    output logic [CNT_W-1:0]     xfer_cnt
);

    localparam int W  = 4 * LANES;
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

    // Per-lane slice function; the reserved mode yields an all-zero word.
    function automatic logic [W-1:0] lane_op(input logic [1:0] mode,
                                              input logic [W-1:0] a,
                                              input logic [W-1:0] b);
        logic [W-1:0] c;
        c = {W{1'b0}};
        case (mode)
            2'd0: begin
                for (int k = 0; k < LANES; k++) begin
                    c[4*k]   = ~a[4*k];
                    c[4*k+1] = ~b[4*k];
                    c[4*k+2] = ~b[4*k+1];
                    c[4*k+3] = ~((a[4*k+1] | a[4*k+2]) &
                                 (b[4*k+1] | b[4*k+2]) &
                                 (a[4*k+3] | b[4*k+3]));
                end
            end
            2'd1:    c = ~a;
            2'd2:    c = ~b;
            default: c = {W{1'b0}};
        endcase
        return c;
    endfunction

    // Pointer advance with wrap at DEPTH-1 (DEPTH need not be a power of two).
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        logic [PW-1:0] n;
        if (p == PTR_LAST) begin
            n = {PW{1'b0}};
        end else begin
            n = p + PW'(1);
        end
        return n;
    endfunction

    logic [W-1:0]     mem_r [DEPTH];
    logic [PW-1:0]    wr_ptr_r;
    logic [PW-1:0]    rd_ptr_r;
    logic [CW-1:0]    count_r;
    logic [CW-1:0]    count_nxt_s;
    logic             err_r;
    logic [CNT_W-1:0] xfer_cnt_r;
    logic             push_s;
    logic             pop_s;
    logic [W-1:0]     result_s;

    // rst_n gating keeps in_ready low throughout reset, when count_r alone would say "not full".
    assign in_ready  = rst_n & (count_r < CNT_FULL);
    assign out_valid = (count_r != {CW{1'b0}});
    assign push_s    = in_valid & in_ready;
    assign pop_s     = out_valid & out_ready;
    assign result_s  = lane_op(in_mode, in_a, in_b);
    assign err       = err_r;
    assign xfer_cnt  = xfer_cnt_r;

    // Head of queue, forced to zero when empty.
    always_comb begin
        out_c = {W{1'b0}};
        if (count_r != {CW{1'b0}}) begin
            out_c = mem_r[rd_ptr_r];
        end else begin
            out_c = {W{1'b0}};
        end
    end

    // Occupancy next-state; simultaneous push and pop leaves it unchanged.
    always_comb begin
        count_nxt_s = count_r;
        if (push_s && !pop_s) begin
            count_nxt_s = count_r + CW'(1);
        end else if (!push_s && pop_s) begin
            count_nxt_s = count_r - CW'(1);
        end else begin
            count_nxt_s = count_r;
        end
    end

    // FIFO storage; inputs are only captured on an accepted word, so idle-cycle X never enters state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {W{1'b0}};
            end
        end else if (push_s) begin
            mem_r[wr_ptr_r] <= result_s;
        end
    end

    // Pointers, occupancy, sticky error and transfer counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r   <= {PW{1'b0}};
            rd_ptr_r   <= {PW{1'b0}};
            count_r    <= {CW{1'b0}};
            err_r      <= 1'b0;
            xfer_cnt_r <= {CNT_W{1'b0}};
        end else begin
            count_r <= count_nxt_s;
            if (push_s) begin
                wr_ptr_r <= ptr_inc(wr_ptr_r);
            end
            if (pop_s) begin
                rd_ptr_r   <= ptr_inc(rd_ptr_r);
                xfer_cnt_r <= xfer_cnt_r + CNT_W'(1);
            end
            if (push_s && (in_mode == 2'd3)) begin
                err_r <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_inv_oai_slice_pipe.sv
// Directed bench for inv_oai_slice_pipe with hand-computed results (LANES=9, DEPTH=2, CNT_W=4).
module tb_inv_oai_slice_pipe;

    localparam int W = 36;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic [1:0]   in_mode;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_c;
    logic         err;
    logic [3:0]   xfer_cnt;

    int n_checks;
    int n_errors;

    inv_oai_slice_pipe #(.LANES(9), .DEPTH(2), .CNT_W(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_mode   (in_mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_c     (out_c),
        .err       (err),
        .xfer_cnt  (xfer_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One word in, one word out with out_ready held high.
    task automatic send(input string tag, input logic [1:0] m, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [W-1:0] exp);
        chk({tag, "_rdy"}, in_ready, 64'd1);
        in_valid = 1'b1;
        in_mode  = m;
        in_a     = a;
        in_b     = b;
        step();
        in_valid = 1'b0;
        chk({tag, "_vld"}, out_valid, 64'd1);
        chk(tag, out_c, exp);
        step();
        chk({tag, "_empty"}, out_valid, 64'd0);
    endtask

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_a      = 36'h0;
        in_b      = 36'h0;
        in_mode   = 2'd0;
        out_ready = 1'b0;
        step();
        chk("rst_rdy", in_ready, 64'd0);
        chk("rst_vld", out_valid, 64'd0);
        chk("rst_c", out_c, 64'd0);
        chk("rst_err", err, 64'd0);
        chk("rst_cnt", xfer_cnt, 64'd0);
        rst_n = 1'b1;
        step();

        // Slice mode and the pass-through inversions
        out_ready = 1'b1;
        send("m0_zero", 2'd0, 36'h0, 36'h0, 36'hF_FFFF_FFFF);
        chk("cnt_one", xfer_cnt, 64'd1);
        send("m0_a1", 2'd0, 36'hF_FFFF_FFFF, 36'h0, 36'hE_EEEE_EEEE);
        send("m0_ab1", 2'd0, 36'hF_FFFF_FFFF, 36'hF_FFFF_FFFF, 36'h0);
        send("m0_mix", 2'd0, 36'h6_6666_6666, 36'hA_AAAA_AAAA, 36'h3_3333_3333);
        send("m1", 2'd1, 36'h0_0000_000F, 36'h5_5555_5555, 36'hF_FFFF_FFF0);
        send("m2", 2'd2, 36'h5_5555_5555, 36'h8_0000_0000, 36'h7_FFFF_FFFF);
        chk("err_clean", err, 64'd0);

        // Backpressure: fill, stall, drain in order with a simultaneous push/pop
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_mode   = 2'd1;
        in_a      = 36'h1;
        step();
        chk("bp_rdy1", in_ready, 64'd1);
        in_a = 36'h2;
        step();
        chk("bp_full", in_ready, 64'd0);
        in_a = 36'h3;
        step();
        chk("bp_hold_rdy", in_ready, 64'd0);
        chk("bp_hold_c", out_c, 36'hF_FFFF_FFFE);
        chk("bp_hold_vld", out_valid, 64'd1);
        out_ready = 1'b1;
        step();
        chk("bp_w2", out_c, 36'hF_FFFF_FFFD);
        chk("bp_rdy_back", in_ready, 64'd1);
        step();
        in_valid = 1'b0;
        chk("bp_w3", out_c, 36'hF_FFFF_FFFC);
        chk("bp_w3_vld", out_valid, 64'd1);
        step();
        chk("bp_drained", out_valid, 64'd0);

        // Reserved mode sets the sticky flag without disturbing later words
        send("m3", 2'd3, 36'hF_FFFF_FFFF, 36'h1_2345_6789, 36'h0);
        chk("err_set", err, 64'd1);
        send("m0_after", 2'd0, 36'h0, 36'h0, 36'hF_FFFF_FFFF);
        chk("err_sticky", err, 64'd1);

        // Full FIFO, then asynchronous reset mid-cycle
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_mode   = 2'd0;
        step();
        step();
        in_valid = 1'b0;
        chk("pre_rst_full", in_ready, 64'd0);
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_vld", out_valid, 64'd0);
        chk("arst_rdy", in_ready, 64'd0);
        chk("arst_cnt", xfer_cnt, 64'd0);
        chk("arst_c", out_c, 64'd0);
        chk("arst_err", err, 64'd0);
        step();
        rst_n = 1'b1;
        #1;
        chk("post_rst_rdy", in_ready, 64'd1);
        chk("post_rst_vld", out_valid, 64'd0);

        // Counter wrap with a 4-bit counter
        out_ready = 1'b1;
        for (int i = 0; i < 17; i++) begin
            send("wrap", 2'd1, 36'h0, 36'h0, 36'hF_FFFF_FFFF);
            if (i == 15) begin
                chk("cnt_wrap0", xfer_cnt, 64'd0);
            end
        end
        chk("cnt_wrap1", xfer_cnt, 64'd1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
